// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit_pkg : core-wide constants and fetch state encoding     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fetch_unit_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_WAIT = 2'd1;
    localparam fetch_state_t ST_DROP = 2'd2;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit_if : instruction-memory request/response bundle        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_buffer : single-entry valid/ready holding register          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    input  logic            load_misaligned,
    input  logic            flush,
    output logic            valid,
    input  logic            ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr,
    output logic            misaligned
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_misaligned;

    // A load wins over flush so a fault entry can replace the flushed one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_instr      <= '0;
            r_misaligned <= 1'b0;
        end else if (load) begin
            r_valid      <= 1'b1;
            r_pc         <= load_pc;
            r_instr      <= load_instr;
            r_misaligned <= load_misaligned;
        end else if (flush || ready) begin
            r_valid      <= 1'b0;
        end
    end

    assign valid      = r_valid;
    assign pc         = r_pc;
    assign instr      = r_instr;
    assign misaligned = r_misaligned;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit : RV32I fetch stage, PC owner, redirect/flush handling |
// | Option macro: FETCH_MISALIGN_CHECK_EN (misaligned-target fault)   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
    input  logic             clk,
    input  logic             rst,
    fetch_unit_if.master     imem,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [XLEN-1:0]  if_pc,
    output logic [XLEN-1:0]  if_instr,
    output logic             if_misaligned
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            w_req_valid;
    logic            w_accept;
    logic            w_rsp_load;
    logic            w_fault;
    logic            w_buf_load;
    logic            w_unused_lsb;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_fault = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign w_fault = 1'b0;
`endif
    assign w_unused_lsb = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A response in DROP retires the stale fetch even if a redirect arrives too.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (imem.imem_rsp_valid)  w_state_next = ST_IDLE;
                else if (redirect_valid)  w_state_next = ST_DROP;
            end
            ST_DROP: if (imem.imem_rsp_valid) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req_valid = (r_state == ST_IDLE) && (!if_valid || if_ready)
                      && !redirect_valid && !rst;
        imem.imem_req_valid = w_req_valid;
        imem.imem_req_addr  = r_pc;
    end

    assign w_accept   = w_req_valid && imem.imem_req_ready;
    assign w_rsp_load = (r_state == ST_WAIT) && imem.imem_rsp_valid && !redirect_valid;
    assign w_buf_load = w_rsp_load || w_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc     <= align_pc(redirect_pc);
        end else if (w_accept) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + PC_INC;
        end
    end

    fetch_buffer u_buffer (
        .clk             (clk),
        .rst             (rst),
        .load            (w_buf_load),
        .load_pc         (w_fault ? redirect_pc : r_req_pc),
        .load_instr      (w_fault ? INSTR_NOP : imem.imem_rsp_data),
        .load_misaligned (w_fault),
        .flush           (redirect_valid),
        .valid           (if_valid),
        .ready           (if_ready),
        .pc              (if_pc),
        .instr           (if_instr),
        .misaligned      (if_misaligned)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_unit : directed and random checks of fetch_unit          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready, if_misaligned;
    logic [31:0] if_pc, if_instr;

    always #5 clk = ~clk;

    fetch_unit_if imem();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_misaligned  (if_misaligned)
    );

    int checks = 0;
    int errors = 0;

    // memory model
    bit          mem_busy = 0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = '0;
    int          lat_min = 1, lat_max = 1;

    // reference model: next expected fetch address and decode stream
    logic [31:0] exp_fetch = RESET_PC;
    logic [31:0] exp_dec   = RESET_PC;
    logic [31:0] fault_pc  = '0;
    bit          fault_pend = 0;
    int          consumed_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic tick();
        bit          s_rst, s_acc;
        logic [31:0] s_addr;
        #1;
        s_rst  = rst;
        s_acc  = imem.imem_req_valid && imem.imem_req_ready;
        s_addr = imem.imem_req_addr;
        if (s_rst) begin
            checks++;
            if (imem.imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL req_in_reset: got %b want 0", imem.imem_req_valid);
            end
        end else begin
            if (redirect_valid) begin
                checks++;
                if (imem.imem_req_valid !== 1'b0) begin
                    errors++; $display("FAIL req_on_redirect: got %b want 0", imem.imem_req_valid);
                end
            end
            if (s_acc) begin
                checks++;
                if (mem_busy !== 1'b0) begin
                    errors++; $display("FAIL one_outstanding: request accepted while busy, addr %h", s_addr);
                end
                checks++;
                if (s_addr !== exp_fetch) begin
                    errors++; $display("FAIL req_addr: got %h want %h", s_addr, exp_fetch);
                end
                exp_fetch = exp_fetch + 32'd4;
            end
            if (if_valid && if_ready) begin
                consumed_cnt++;
                checks++;
                if (fault_pend) begin
                    if ({if_pc, if_instr, if_misaligned} !== {fault_pc, INSTR_NOP, 1'b1}) begin
                        errors++; $display("FAIL fault_entry: got pc %h instr %h mis %b want pc %h instr %h mis 1",
                                           if_pc, if_instr, if_misaligned, fault_pc, INSTR_NOP);
                    end
                    fault_pend = 0;
                end else begin
                    if ({if_pc, if_instr, if_misaligned} !== {exp_dec, mem_word(exp_dec), 1'b0}) begin
                        errors++; $display("FAIL decode_entry: got pc %h instr %h mis %b want pc %h instr %h mis 0",
                                           if_pc, if_instr, if_misaligned, exp_dec, mem_word(exp_dec));
                    end
                    exp_dec = exp_dec + 32'd4;
                end
            end
            if (redirect_valid) begin
                exp_fetch  = {redirect_pc[31:2], 2'b00};
                exp_dec    = exp_fetch;
                fault_pend = MIS_EN && (redirect_pc[1:0] != 2'b00);
                fault_pc   = redirect_pc;
            end
        end
        @(posedge clk);
        #1;
        if (s_rst) begin
            mem_busy   = 0;
            exp_fetch  = RESET_PC;
            exp_dec    = RESET_PC;
            fault_pend = 0;
        end else if (s_acc) begin
            mem_busy = 1;
            mem_wait = int'($urandom_range(lat_max, lat_min)) - 1;
            mem_addr = s_addr;
        end
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = $urandom;
        if (mem_busy) begin
            if (mem_wait == 0) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = mem_word(mem_addr);
                mem_busy = 0;
            end else begin
                mem_wait--;
            end
        end
    endtask

    task automatic wait_req(input string name);
        bit got = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (imem.imem_req_valid && imem.imem_req_ready) begin got = 1; break; end
            tick();
        end
        checks++;
        if (!got) begin errors++; $display("FAIL %s_req_timeout: got none want request in 40 cycles", name); end
    endtask

    task automatic wait_valid(input string name);
        bit got = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (if_valid) begin got = 1; break; end
            tick();
        end
        checks++;
        if (!got) begin errors++; $display("FAIL %s_valid_timeout: got none want if_valid in 40 cycles", name); end
    endtask

    task automatic test_reset();
        rst = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem.imem_req_ready = 1'b1; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = '0;
        lat_min = 1; lat_max = 1;
        tick(); tick();
        #1;
        checks += 5;
        if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem.imem_req_valid); end
        if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
        if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
        if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr: got %h want 0", if_instr); end
        if (if_misaligned !== 1'b0) begin errors++; $display("FAIL reset_if_mis: got %b want 0", if_misaligned); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        for (int n = 0; n < 7; n++) begin
            bit exp_rv, exp_iv;
            exp_rv = (n % 2 == 0);
            exp_iv = (n >= 2) && (n % 2 == 0);
            #1;
            checks += 2;
            if (imem.imem_req_valid !== exp_rv) begin
                errors++; $display("FAIL seq_req_valid[%0d]: got %b want %b", n, imem.imem_req_valid, exp_rv);
            end
            if (if_valid !== exp_iv) begin
                errors++; $display("FAIL seq_if_valid[%0d]: got %b want %b", n, if_valid, exp_iv);
            end
            if (exp_rv) begin
                checks++;
                if (imem.imem_req_addr !== 32'(n * 2)) begin
                    errors++; $display("FAIL seq_req_addr[%0d]: got %h want %h", n, imem.imem_req_addr, 32'(n * 2));
                end
            end
            if (exp_iv) begin
                checks++;
                if (if_pc !== 32'((n / 2 - 1) * 4) || if_instr !== mem_word(32'((n / 2 - 1) * 4))) begin
                    errors++; $display("FAIL seq_if_entry[%0d]: got pc %h instr %h want pc %h", n, if_pc, if_instr,
                                       32'((n / 2 - 1) * 4));
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_pc, held_instr;
        if_ready = 1'b0;
        wait_valid("stall");
        held_pc = if_pc; held_instr = if_instr;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks += 2;
            if (imem.imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL stall_no_req[%0d]: got %b want 0", n, imem.imem_req_valid);
            end
            if (if_pc !== held_pc || if_instr !== held_instr || if_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d]: got pc %h instr %h want pc %h instr %h", n, if_pc,
                                   if_instr, held_pc, held_instr);
            end
            tick();
        end
        if_ready = 1'b1;
        #1;
        checks++;
        if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== held_pc + 32'd4) begin
            errors++; $display("FAIL stall_release: got valid %b addr %h want valid 1 addr %h",
                               imem.imem_req_valid, imem.imem_req_addr, held_pc + 32'd4);
        end
        tick();
    endtask

    task automatic test_redirect_wait();
        lat_min = 3; lat_max = 3; if_ready = 1'b1;
        wait_req("rdw");
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            #1;
            checks++;
            if (imem.imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL rdw_drop_no_req[%0d]: got %b want 0", n, imem.imem_req_valid);
            end
            tick();
        end
        #1;
        checks++;
        if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h100) begin
            errors++; $display("FAIL rdw_next_req: got valid %b addr %h want valid 1 addr 100",
                               imem.imem_req_valid, imem.imem_req_addr);
        end
        lat_min = 1; lat_max = 1;
        wait_valid("rdw");
        checks++;
        if (if_pc !== 32'h100) begin errors++; $display("FAIL rdw_first_pc: got %h want 100", if_pc); end
        tick();
    endtask

    task automatic test_redirect_rsp();
        lat_min = 1; lat_max = 1; if_ready = 1'b1;
        wait_req("rdr");
        tick();
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h200) begin
            errors++; $display("FAIL rdr_same_cycle: got if_valid %b req %b addr %h want 0 1 200",
                               if_valid, imem.imem_req_valid, imem.imem_req_addr);
        end
        tick();
        wait_valid("rdr");
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h300) begin
            errors++; $display("FAIL rdr_flush_full: got if_valid %b req %b addr %h want 0 1 300",
                               if_valid, imem.imem_req_valid, imem.imem_req_addr);
        end
        tick();
    endtask

    task automatic test_wrap();
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_req("wrap0");
        checks++;
        if (imem.imem_req_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_first: got %h want fffffffc", imem.imem_req_addr);
        end
        tick();
        wait_req("wrap1");
        checks++;
        if (imem.imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h want 0", imem.imem_req_addr); end
        tick();
    endtask

    task automatic test_misalign();
        if_ready = 1'b0;
        wait_valid("mis");
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        checks++;
        if ({if_valid, if_misaligned, if_pc, if_instr, imem.imem_req_valid} !== {1'b1, 1'b1, 32'h102, 32'h13, 1'b0}) begin
            errors++; $display("FAIL mis_fault: got v %b mis %b pc %h instr %h req %b want 1 1 102 13 0",
                               if_valid, if_misaligned, if_pc, if_instr, imem.imem_req_valid);
        end
        tick();
        #1;
        checks++;
        if (imem.imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b want 0", imem.imem_req_valid); end
        tick();
        if_ready = 1'b1;
        #1;
`endif
        checks++;
        if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h100 || if_misaligned !== MIS_EN) begin
            errors++; $display("FAIL mis_next_req: got req %b addr %h mis %b want 1 100 %b",
                               imem.imem_req_valid, imem.imem_req_addr, if_misaligned, MIS_EN);
        end
        if_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int start_cnt = consumed_cnt;
        lat_min = 1; lat_max = 4;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(199, 0) == 0);
            redirect_valid = !rst && ($urandom_range(15, 0) == 0);
            case ($urandom_range(3, 0))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                default: redirect_pc = $urandom & 32'h0000_FFFC;
            endcase
            imem.imem_req_ready = ($urandom_range(3, 0) != 0);
            if_ready = ($urandom_range(2, 0) != 0);
            tick();
        end
        rst = 1'b0; redirect_valid = 1'b0;
        checks++;
        if (consumed_cnt - start_cnt < 100) begin
            errors++; $display("FAIL random_progress: got %0d consumed want >= 100", consumed_cnt - start_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_wrap();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
